// File: rtl/data_mem_lsu_if.sv
// LSU-to-data-memory request/response bundle: req/gnt accept, then a one-cycle rvalid strobe
// carrying rdata/err. The master drives the request side; the slave drives grant and response.
interface data_mem_lsu_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [2:0]            size_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i, size_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, size_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-lane data memory for RISC-V loads/stores: response WAIT_STATES+1 cycles after accept.
// gnt only in IDLE/RESP, so at most one access is in flight; no backpressure on the response.
module data_mem_lsu #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1 << (ADDR_WIDTH - 2),
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_lsu_if.slave bus
);
    localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  gnt, accept, enter_resp, commit;
    logic                  op_we, op_err;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [2:0]            op_size;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [1:0]            lane;
    logic [31:0]           widx;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           rd_word, shifted, load_val, sdat;
    logic [3:0]            be;

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] = '0;
    end

    assign gnt          = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept       = bus.req_i && gnt;
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = (state_q == S_RESP);
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = NO_WAIT ? S_RESP : S_BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d    = accept ? bus.we_i    : we_q;
        addr_d  = accept ? bus.addr_i  : addr_q;
        size_d  = accept ? bus.size_i  : size_q;
        wdata_d = accept ? bus.wdata_i : wdata_q;
    end

    // With no wait states the access resolves on its own accept edge, so use the live inputs.
    always_comb begin
        op_we    = NO_WAIT ? bus.we_i    : we_q;
        op_addr  = NO_WAIT ? bus.addr_i  : addr_q;
        op_size  = NO_WAIT ? bus.size_i  : size_q;
        op_wdata = NO_WAIT ? bus.wdata_i : wdata_q;
        lane     = op_addr[1:0];
        widx     = 32'(op_addr >> 2);
        idx      = widx[IDX_W-1:0];
        op_err   = (op_size == 3'b011) || (op_size[2:1] == 2'b11) || (op_we && op_size[2]) ||
                   ((op_size[1:0] == 2'b01) && lane[0]) ||
                   ((op_size[1:0] == 2'b10) && (lane != 2'b00)) ||
                   (widx >= 32'(MEM_DEPTH));
        enter_resp = rst_n && (((state_q == S_BUSY) && (cnt_q == 4'd0)) || (accept && NO_WAIT));
        commit     = enter_resp && op_we && !op_err;
    end

    always_comb begin
        rd_word  = mem_q[idx];
        shifted  = rd_word >> {lane, 3'b000};
        load_val = '0;
        be       = 4'b1111;
        sdat     = op_wdata;
        case (op_size[1:0])
            2'b00: begin
                load_val = {{24{shifted[7] & ~op_size[2]}}, shifted[7:0]};
                be       = 4'b0001 << lane;
                sdat     = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                load_val = {{16{shifted[15] & ~op_size[2]}}, shifted[15:0]};
                be       = 4'b0011 << lane;
                sdat     = {2{op_wdata[15:0]}};
            end
            default: load_val = shifted;
        endcase
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = op_err;
            rdata_d = (op_err || op_we) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is deliberately outside reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= sdat[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Three instances (default, 64-word with 3 wait states, zero wait states) checked against a
// byte-addressed reference memory.
module tb_data_mem_lsu;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    data_mem_lsu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
    data_mem_lsu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifb ();
    data_mem_lsu_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifc ();

    data_mem_lsu #(.WAIT_STATES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    data_mem_lsu #(.MEM_DEPTH(64), .WAIT_STATES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    data_mem_lsu #(.WAIT_STATES(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mb [3][1024];

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] xrd;
        logic        xer;
    } vec_t;

    vec_t dv [16] = '{
        '{1'b1, 10'h004, 3'd2, 32'hDEADBEEF, 32'h00000000, 1'b0},
        '{1'b0, 10'h004, 3'd2, 32'h00000000, 32'hDEADBEEF, 1'b0},
        '{1'b1, 10'h005, 3'd0, 32'hAAAAAA80, 32'h00000000, 1'b0},
        '{1'b0, 10'h005, 3'd0, 32'h00000000, 32'hFFFFFF80, 1'b0},
        '{1'b0, 10'h005, 3'd4, 32'h00000000, 32'h00000080, 1'b0},
        '{1'b0, 10'h004, 3'd2, 32'h00000000, 32'hDEAD80EF, 1'b0},
        '{1'b0, 10'h006, 3'd1, 32'h00000000, 32'hFFFFDEAD, 1'b0},
        '{1'b0, 10'h006, 3'd5, 32'h00000000, 32'h0000DEAD, 1'b0},
        '{1'b0, 10'h003, 3'd1, 32'h00000000, 32'h00000000, 1'b1},
        '{1'b1, 10'h002, 3'd2, 32'h12345678, 32'h00000000, 1'b1},
        '{1'b0, 10'h000, 3'd2, 32'h00000000, 32'h00000000, 1'b0},
        '{1'b1, 10'h00A, 3'd1, 32'h5555BEEF, 32'h00000000, 1'b0},
        '{1'b0, 10'h008, 3'd2, 32'h00000000, 32'hBEEF0000, 1'b0},
        '{1'b0, 10'h00B, 3'd0, 32'h00000000, 32'hFFFFFFBE, 1'b0},
        '{1'b1, 10'h010, 3'd4, 32'h000000FF, 32'h00000000, 1'b1},
        '{1'b0, 10'h010, 3'd2, 32'h00000000, 32'h00000000, 1'b0}
    };

    function automatic int ws_of(input int sel);
        return (sel == 1) ? 3 : ((sel == 2) ? 0 : 1);
    endfunction

    // Reference: byte-addressed little-endian memory, access legality from size/alignment/depth.
    function automatic void model(input int sel, input logic we, input logic [9:0] addr,
                                  input logic [2:0] size, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int nb = 1;
        bit sgn = 0;
        bit ok = 1;
        int a = int'(addr);
        int depth = (sel == 1) ? 64 : 256;
        logic [31:0] v = '0;
        case (size)
            3'd0: begin nb = 1; sgn = 1; end
            3'd1: begin nb = 2; sgn = 1; end
            3'd2: nb = 4;
            3'd4: nb = 1;
            3'd5: nb = 2;
            default: ok = 0;
        endcase
        er = !ok || (we && size >= 3'd4) || (a % nb != 0) || (a / 4 >= depth);
        rd = '0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mb[sel][a+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[sel][a+i];
                if (sgn && nb < 4 && v[8*nb-1]) begin
                    for (int j = 8 * nb; j < 32; j++) v[j] = 1'b1;
                end
                rd = v;
            end
        end
    endfunction

    task automatic drive(input int sel, input logic req, input logic we, input logic [9:0] addr,
                         input logic [2:0] size, input logic [31:0] wd);
        case (sel)
            0: begin ifa.req_i = req; ifa.we_i = we; ifa.addr_i = addr; ifa.size_i = size; ifa.wdata_i = wd; end
            1: begin ifb.req_i = req; ifb.we_i = we; ifb.addr_i = addr; ifb.size_i = size; ifb.wdata_i = wd; end
            default: begin ifc.req_i = req; ifc.we_i = we; ifc.addr_i = addr; ifc.size_i = size; ifc.wdata_i = wd; end
        endcase
    endtask

    task automatic sample(input int sel, output logic g, output logic v, output logic [31:0] d,
                          output logic e);
        case (sel)
            0: begin g = ifa.gnt_o; v = ifa.rvalid_o; d = ifa.rdata_o; e = ifa.err_o; end
            1: begin g = ifb.gnt_o; v = ifb.rvalid_o; d = ifb.rdata_o; e = ifb.err_o; end
            default: begin g = ifc.gnt_o; v = ifc.rvalid_o; d = ifc.rdata_o; e = ifc.err_o; end
        endcase
    endtask

    // One access; lat = edges after the accept edge before rvalid is seen, negative on timeout.
    task automatic acc(input int sel, input logic we, input logic [9:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic [31:0] xrd, output logic xer);
        logic g, v;
        int   wt = 0;
        model(sel, we, addr, size, wd, xrd, xer);
        @(negedge clk);
        drive(sel, 1'b1, we, addr, size, wd);
        sample(sel, g, v, rd, er);
        while (!g && wt < 50) begin
            @(negedge clk);
            sample(sel, g, v, rd, er);
            wt++;
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom), 10'($urandom), 3'($urandom), $urandom);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sample(sel, g, v, rd, er);
            if (v) begin
                lat = k;
                break;
            end
        end
        if (wt >= 50) lat = -2;
    endtask

    task automatic test_reset();
        logic g, v, e;
        logic [31:0] d;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        #3;
        drive(0, 1'b1, 1'b1, 10'h004, 3'd2, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        sample(0, g, v, d, e);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b exp 1", g); end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", v); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e); end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] rd, xrd, d;
        logic er, xer, g, v, e;
        int lat;
        for (int i = 0; i < 16; i++) begin
            acc(0, dv[i].we, dv[i].addr, dv[i].size, dv[i].wd, rd, er, lat, xrd, xer);
            checks++; if (rd !== dv[i].xrd) begin errors++; $display("FAIL dir%0d_rdata got %h exp %h", i, rd, dv[i].xrd); end
            checks++; if (er !== dv[i].xer) begin errors++; $display("FAIL dir%0d_err got %b exp %b", i, er, dv[i].xer); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL dir%0d_latency got %0d exp 1", i, lat); end
            if (i == 1 || i == 8) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    sample(0, g, v, d, e);
                    checks++; if (v !== 1'b0 || d !== dv[i].xrd || e !== dv[i].xer) begin
                        errors++; $display("FAIL dir%0d_hold rvalid/rdata/err got %b/%h/%b exp 0/%h/%b", i, v, d, e, dv[i].xrd, dv[i].xer);
                    end
                end
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] rd, xrd;
        logic er, xer;
        int lat;
        acc(1, 1'b0, 10'h100, 3'd2, 32'h0, rd, er, lat, xrd, xer);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL range_lw100 err/rdata got %b/%h exp 1/0", er, rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL range_latency got %0d exp 3", lat); end
        acc(1, 1'b0, 10'h000, 3'b011, 32'h0, rd, er, lat, xrd, xer);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size011 err/rdata got %b/%h exp 1/0", er, rd); end
        acc(1, 1'b1, 10'h0FC, 3'd2, 32'h55AA55AA, rd, er, lat, xrd, xer);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL range_sw0fc err got %b exp 0", er); end
        acc(1, 1'b0, 10'h0FC, 3'd2, 32'h0, rd, er, lat, xrd, xer);
        checks++; if (rd !== 32'h55AA55AA || er !== 1'b0) begin errors++; $display("FAIL range_lw0fc rdata/err got %h/%b exp 55aa55aa/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        logic [31:0] rd, xrd, d;
        logic er, xer, g, v, e;
        int lat;
        int nv = 0;
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 10'(32'h20 + 4 * 0), 3'd2, wd[0]);
        model(2, 1'b1, 10'h20, 3'd2, wd[0], xrd, xer);
        for (int i = 0; i < 4; i++) begin
            sample(2, g, v, d, e);
            checks++; if (g !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b exp 1", i, g); end
            @(posedge clk);
            #1;
            if (i < 3) begin
                drive(2, 1'b1, 1'b1, 10'(32'h20 + 4 * (i + 1)), 3'd2, wd[i+1]);
                model(2, 1'b1, 10'(32'h20 + 4 * (i + 1)), 3'd2, wd[i+1], xrd, xer);
            end else begin
                drive(2, 1'b0, 1'b0, '0, '0, '0);
            end
            @(negedge clk);
            sample(2, g, v, d, e);
            if (v === 1'b1) nv++;
        end
        checks++; if (nv !== 4) begin errors++; $display("FAIL b2b_rvalid_cycles got %0d exp 4", nv); end
        @(negedge clk);
        sample(2, g, v, d, e);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_after got %b exp 0", v); end
        for (int i = 0; i < 4; i++) begin
            acc(2, 1'b0, 10'(32'h20 + 4 * i), 3'd2, 32'h0, rd, er, lat, xrd, xer);
            checks++; if (rd !== wd[i] || er !== 1'b0) begin errors++; $display("FAIL b2b_read%0d rdata/err got %h/%b exp %h/0", i, rd, er, wd[i]); end
            checks++; if (lat !== 0) begin errors++; $display("FAIL b2b_latency%0d got %0d exp 0", i, lat); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, xrd, d;
        logic er, xer, g, v, e;
        int lat;
        acc(0, 1'b1, 10'h008, 3'd2, 32'h11223344, rd, er, lat, xrd, xer);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'h008, 3'd2, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        sample(0, g, v, d, e);
        checks++; if (g !== 1'b0) begin errors++; $display("FAIL busy_gnt got %b exp 0", g); end
        rst_n = 1'b0;
        #1;
        sample(0, g, v, d, e);
        checks++; if (g !== 1'b1 || v !== 1'b0) begin errors++; $display("FAIL midrst_gnt/rvalid got %b/%b exp 1/0", g, v); end
        repeat (2) begin
            @(negedge clk);
            sample(0, g, v, d, e);
            checks++; if (v !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0", v); end
        end
        rst_n = 1'b1;
        acc(0, 1'b0, 10'h008, 3'd2, 32'h0, rd, er, lat, xrd, xer);
        checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL midrst_readback rdata/err got %h/%b exp 11223344/0", rd, er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, xrd;
        logic er, xer;
        int lat, sel;
        logic [9:0] addr;
        for (int i = 0; i < 90; i++) begin
            sel  = i % 3;
            addr = (sel == 1) ? 10'($urandom_range(0, 511)) : 10'($urandom_range(0, 31));
            acc(sel, 1'($urandom), addr, 3'($urandom_range(0, 7)), $urandom, rd, er, lat, xrd, xer);
            checks++; if (rd !== xrd) begin errors++; $display("FAIL rnd%0d_rdata dut%0d addr %h got %h exp %h", i, sel, addr, rd, xrd); end
            checks++; if (er !== xer) begin errors++; $display("FAIL rnd%0d_err dut%0d addr %h got %b exp %b", i, sel, addr, er, xer); end
            checks++; if (lat !== ws_of(sel)) begin errors++; $display("FAIL rnd%0d_latency dut%0d got %0d exp %0d", i, sel, lat, ws_of(sel)); end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1024; i++) mb[s][i] = 8'h00;
        end
        test_reset();
        test_directed();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
